// File: rtl/paddle_motion_ctrl_pkg.sv
// Shared constants for the player paddle: screen bounds, paddle geometry,
// motion tuning and the FSM state encoding used by the controller and debug logic.
package paddle_motion_ctrl_pkg;

  localparam int COORD_W      = 11;
  localparam int X_LEFT       = 144;
  localparam int X_RIGHT      = 783;
  localparam int WIDTH        = 170;
  localparam int X_MIN        = X_LEFT + WIDTH - 1;
  localparam int X_RESET      = 548;
  localparam int Y_BOTTOM     = 509;
  localparam int MIN_SPEED    = 2;
  localparam int MAX_SPEED    = 12;
  localparam int SPEED_W      = 4;
  localparam int ACCEL_FRAMES = 4;
  localparam int ACC_W        = $clog2(ACCEL_FRAMES);

  // Encoding is fixed so renderer/debug views decode it identically.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_MOVE_L = 2'd1,
    ST_MOVE_R = 2'd2
  } state_t;

endpackage

// File: rtl/paddle_motion_ctrl_btn_debounce.sv
// One button input: 2-FF synchroniser, optionally followed by a counter filter
// when PADDLE_DEBOUNCE_EN is defined. Without the macro the output is the
// synchronised level.
module paddle_motion_ctrl_btn_debounce
`ifdef PADDLE_DEBOUNCE_EN
  #(parameter int DEBOUNCE_CYC = 250000)
`endif
  (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic btn_level
);

  logic sync_1;
  logic sync_2;

  // Two-flop synchroniser, runs every clock.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
    end else begin
      sync_1 <= btn_raw;
      sync_2 <= sync_1;
    end
  end

`ifdef PADDLE_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYC + 1);

  logic [CNT_W-1:0] cnt;
  logic             filt;

  // Filtered level flips only after DEBOUNCE_CYC consecutive differing clocks;
  // any return to the current level restarts the count.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt  <= '0;
      filt <= 1'b0;
    end else if (sync_2 == filt) begin
      cnt <= '0;
    end else if (cnt == CNT_W'(DEBOUNCE_CYC - 1)) begin
      cnt  <= '0;
      filt <= sync_2;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign btn_level = filt;
`else
  assign btn_level = sync_2;
`endif

endmodule

// File: rtl/paddle_motion_ctrl.sv
// Per-frame paddle position controller. Buttons steer an IDLE/MOVE_L/MOVE_R
// FSM evaluated once per frame_tick while run is high; speed ramps every
// ACCEL_FRAMES moving frames and pos_x is clamped to the visible field.
// Optional build macro: PADDLE_DEBOUNCE_EN (counter filter on each button).
// Handshake: none; frame_tick is a single-cycle strobe, each high cycle with
// run=1 is one evaluation and results appear on the following clock edge.
module paddle_motion_ctrl
  import paddle_motion_ctrl_pkg::*;
`ifdef PADDLE_DEBOUNCE_EN
  #(parameter int DEBOUNCE_CYC = 250000)
`endif
  (
  input  logic               clk,
  input  logic               reset,
  input  logic               frame_tick,
  input  logic               run,
  input  logic [1:0]         btn,
  output logic [COORD_W-1:0] pos_x,
  output logic [COORD_W-1:0] pos_y,
  output logic               moving,
  output logic               at_wall,
  output logic [1:0]         state_dbg
);

  logic btn_l;
  logic btn_r;

`ifdef PADDLE_DEBOUNCE_EN
  paddle_motion_ctrl_btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_btn_l (
    .clk(clk), .reset(reset), .btn_raw(btn[0]), .btn_level(btn_l));
  paddle_motion_ctrl_btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_btn_r (
    .clk(clk), .reset(reset), .btn_raw(btn[1]), .btn_level(btn_r));
`else
  paddle_motion_ctrl_btn_debounce u_btn_l (
    .clk(clk), .reset(reset), .btn_raw(btn[0]), .btn_level(btn_l));
  paddle_motion_ctrl_btn_debounce u_btn_r (
    .clk(clk), .reset(reset), .btn_raw(btn[1]), .btn_level(btn_r));
`endif

  logic cmd_l;
  logic cmd_r;
  assign cmd_l = btn_l & ~btn_r;
  assign cmd_r = btn_r & ~btn_l;

  state_t             state, state_n;
  logic [SPEED_W-1:0] speed, speed_n;
  logic [ACC_W-1:0]   acc, acc_n;
  logic [SPEED_W-1:0] speed_ramp;
  logic [ACC_W-1:0]   acc_ramp;
  logic               go_l, go_r;
  logic [11:0]        nx;
  logic               eval;

  assign eval = frame_tick & run;

  // Next state, speed ramp and clamped position for an evaluated tick.
  always_comb begin
    state_n    = state;
    speed_n    = speed;
    acc_n      = acc;
    go_l       = 1'b0;
    go_r       = 1'b0;
    speed_ramp = speed;
    acc_ramp   = acc + ACC_W'(1);
    nx         = {1'b0, pos_x};

    // Continuing in the same direction: the bump applies to this frame's step.
    if (acc == ACC_W'(ACCEL_FRAMES - 1)) begin
      acc_ramp   = '0;
      speed_ramp = (speed >= SPEED_W'(MAX_SPEED)) ? SPEED_W'(MAX_SPEED)
                                                  : speed + SPEED_W'(1);
    end

    case (state)
      ST_IDLE: begin
        if (cmd_l) begin
          state_n = ST_MOVE_L; speed_n = SPEED_W'(MIN_SPEED); acc_n = '0; go_l = 1'b1;
        end else if (cmd_r) begin
          state_n = ST_MOVE_R; speed_n = SPEED_W'(MIN_SPEED); acc_n = '0; go_r = 1'b1;
        end
      end
      ST_MOVE_L: begin
        if (cmd_l) begin
          speed_n = speed_ramp; acc_n = acc_ramp; go_l = 1'b1;
        end else if (cmd_r) begin
          state_n = ST_MOVE_R; speed_n = SPEED_W'(MIN_SPEED); acc_n = '0; go_r = 1'b1;
        end else begin
          state_n = ST_IDLE; speed_n = '0; acc_n = '0;
        end
      end
      ST_MOVE_R: begin
        if (cmd_r) begin
          speed_n = speed_ramp; acc_n = acc_ramp; go_r = 1'b1;
        end else if (cmd_l) begin
          state_n = ST_MOVE_L; speed_n = SPEED_W'(MIN_SPEED); acc_n = '0; go_l = 1'b1;
        end else begin
          state_n = ST_IDLE; speed_n = '0; acc_n = '0;
        end
      end
      default: begin
        state_n = ST_IDLE; speed_n = '0; acc_n = '0;
      end
    endcase

    // 12-bit arithmetic so neither direction can wrap before clamping.
    if (go_l) begin
      nx = {1'b0, pos_x} - 12'(speed_n);
      if (nx < 12'(X_MIN)) nx = 12'(X_MIN);
    end else if (go_r) begin
      nx = {1'b0, pos_x} + 12'(speed_n);
      if (nx > 12'(X_RIGHT)) nx = 12'(X_RIGHT);
    end
  end

  // State/position registers; everything holds except on an evaluated tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      speed   <= '0;
      acc     <= '0;
      pos_x   <= COORD_W'(X_RESET);
      moving  <= 1'b0;
      at_wall <= 1'b0;
    end else if (eval) begin
      state   <= state_n;
      speed   <= speed_n;
      acc     <= acc_n;
      pos_x   <= nx[COORD_W-1:0];
      moving  <= (state_n == ST_MOVE_L) || (state_n == ST_MOVE_R);
      at_wall <= (nx == 12'(X_MIN)) || (nx == 12'(X_RIGHT));
    end
  end

  assign pos_y     = COORD_W'(Y_BOTTOM);
  assign state_dbg = state;

endmodule

// File: tb/tb_paddle_motion_ctrl.sv
// Bench for paddle_motion_ctrl: table of per-tick vectors plus hand sequences
// for wall clamps, back-to-back ticks, freeze and mid-frame reset.
module tb_paddle_motion_ctrl;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        frame_tick = 1'b0;
  logic        run = 1'b0;
  logic [1:0]  btn = 2'b00;
  logic [10:0] pos_x, pos_y;
  logic        moving, at_wall;
  logic [1:0]  state_dbg;

  always #5 clk = ~clk;

`ifdef PADDLE_DEBOUNCE_EN
  localparam int SETTLE = 14;
  paddle_motion_ctrl #(.DEBOUNCE_CYC(8)) dut (
`else
  localparam int SETTLE = 3;
  paddle_motion_ctrl dut (
`endif
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .run(run), .btn(btn),
    .pos_x(pos_x), .pos_y(pos_y), .moving(moving), .at_wall(at_wall),
    .state_dbg(state_dbg));

  localparam logic [1:0] S_IDLE = 2'd0, S_L = 2'd1, S_R = 2'd2;
  localparam logic [1:0] B_NONE = 2'b00, B_LEFT = 2'b01, B_RIGHT = 2'b10, B_BOTH = 2'b11;

  int checks = 0;
  int errors = 0;

  // ---------------- scoreboard ----------------
  // packed expectation: {pos_x, moving, at_wall, state}
  logic [14:0] exp_q[$];
  logic        tick_seen = 1'b0;
  int          tick_no = 0;

  always @(posedge clk) tick_seen <= frame_tick;

  always @(negedge clk) begin
    if (tick_seen) begin
      logic [14:0] e;
      tick_no++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL tick%0d scoreboard empty: got x=%0d mv=%0d wall=%0d st=%0d",
                 tick_no, pos_x, moving, at_wall, state_dbg);
      end else begin
        e = exp_q.pop_front();
        if ({pos_x, moving, at_wall, state_dbg} !== e || pos_y !== 11'd509) begin
          errors++;
          $display("FAIL tick%0d got x=%0d y=%0d mv=%0d wall=%0d st=%0d, want x=%0d y=509 mv=%0d wall=%0d st=%0d",
                   tick_no, pos_x, pos_y, moving, at_wall, state_dbg,
                   e[14:4], e[3], e[2], e[1:0]);
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, act, want);
    end
  endtask

  // ---------------- driver tasks ----------------
  int cur_x = 548;

  task automatic tick(input logic [1:0] b, input logic r, input int x,
                      input logic mv, input logic wall, input logic [1:0] st);
    btn = b;
    run = r;
    repeat (SETTLE) @(posedge clk);
    #1;
    exp_q.push_back({11'(x), mv, wall, st});
    frame_tick = 1'b1;
    @(posedge clk);
    #1 frame_tick = 1'b0;
    cur_x = x;
  endtask

  // n ticks in one direction from IDLE, then release; speeds 2,2,2,2,3
  task automatic burst(input logic right, input int n);
    for (int i = 0; i < n; i++) begin
      int sp;
      sp = (i < 4) ? 2 : 3;
      if (right) tick(B_RIGHT, 1'b1, cur_x + sp, 1'b1, 1'b0, S_R);
      else       tick(B_LEFT,  1'b1, cur_x - sp, 1'b1, 1'b0, S_L);
    end
    tick(B_NONE, 1'b1, cur_x, 1'b0, 1'b0, S_IDLE);
  endtask

  task automatic pulse_reset(input string tag);
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1;
    chk({tag, "_pos_x"}, pos_x, 548);
    chk({tag, "_pos_y"}, pos_y, 509);
    chk({tag, "_moving"}, moving, 0);
    chk({tag, "_at_wall"}, at_wall, 0);
    chk({tag, "_state"}, state_dbg, 0);
    reset = 1'b0;
    cur_x = 548;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [1:0]  b;
    logic        r;
    int          x;
    logic        mv;
    logic        wall;
    logic [1:0]  st;
  } vec_t;

  function automatic vec_t mk(input logic [1:0] b, input logic r, input int x,
                              input logic mv, input logic wall, input logic [1:0] st);
    vec_t v;
    v.b = b; v.r = r; v.x = x; v.mv = mv; v.wall = wall; v.st = st;
    return v;
  endfunction

  vec_t tbl[$];

  initial begin
    int right_xs[9] = '{550, 552, 554, 556, 559, 562, 565, 568, 572};

    // idle after reset
    for (int i = 0; i < 3; i++) tbl.push_back(mk(B_NONE, 1, 548, 0, 0, S_IDLE));
    // right held: speeds 2,2,2,2,3,3,3,3,4
    for (int i = 0; i < 9; i++) tbl.push_back(mk(B_RIGHT, 1, right_xs[i], 1, 0, S_R));
    // reverse at speed 4 -> restart at 2 leftwards; both buttons -> idle
    tbl.push_back(mk(B_LEFT, 1, 570, 1, 0, S_L));
    tbl.push_back(mk(B_BOTH, 1, 570, 0, 0, S_IDLE));
    // frozen with right held
    for (int i = 0; i < 5; i++) tbl.push_back(mk(B_RIGHT, 0, 570, 0, 0, S_IDLE));
    tbl.push_back(mk(B_RIGHT, 1, 572, 1, 0, S_R));
    // frozen while moving, then resume with acc not advanced
    for (int i = 0; i < 2; i++) tbl.push_back(mk(B_RIGHT, 0, 572, 1, 0, S_R));
    tbl.push_back(mk(B_RIGHT, 1, 574, 1, 0, S_R));

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset_pos_x", pos_x, 548);
    chk("reset_pos_y", pos_y, 509);
    chk("reset_moving", moving, 0);
    chk("reset_at_wall", at_wall, 0);
    chk("reset_state", state_dbg, 0);
    reset = 1'b0;

    foreach (tbl[i]) tick(tbl[i].b, tbl[i].r, tbl[i].x, tbl[i].mv, tbl[i].wall, tbl[i].st);

    // back-to-back frame ticks: two evaluations (acc 1->2->3), then the bump to 3
    btn = B_RIGHT;
    repeat (SETTLE) @(posedge clk);
    #1;
    exp_q.push_back({11'd576, 1'b1, 1'b0, S_R});
    exp_q.push_back({11'd578, 1'b1, 1'b0, S_R});
    frame_tick = 1'b1;
    repeat (2) @(posedge clk);
    #1 frame_tick = 1'b0;
    tick(B_RIGHT, 1, 581, 1, 0, S_R);

    // reset between ticks while moving; motion restarts at minimum speed
    pulse_reset("midreset");
    tick(B_RIGHT, 1, 550, 1, 0, S_R);

    // right wall: reach 780, then 782, clamp 783, hold, leave
    pulse_reset("rwall_reset");
    for (int i = 0; i < 29; i++) burst(1'b1, 4);
    chk("reach_780", cur_x, 780);
    tick(B_RIGHT, 1, 782, 1, 0, S_R);
    tick(B_RIGHT, 1, 783, 1, 1, S_R);
    tick(B_RIGHT, 1, 783, 1, 1, S_R);
    tick(B_LEFT,  1, 781, 1, 0, S_L);
    tick(B_NONE,  1, 781, 0, 0, S_IDLE);

    // left wall: reach 314, then clamp to 313 with no underflow
    pulse_reset("lwall_reset");
    for (int i = 0; i < 6; i++) burst(1'b0, 5);
    for (int i = 0; i < 21; i++) burst(1'b0, 4);
    chk("reach_314", cur_x, 314);
    tick(B_LEFT,  1, 313, 1, 1, S_L);
    tick(B_LEFT,  1, 313, 1, 1, S_L);
    tick(B_RIGHT, 1, 315, 1, 0, S_R);
    tick(B_NONE,  1, 315, 0, 0, S_IDLE);

`ifdef PADDLE_DEBOUNCE_EN
    // short glitch on the right button is filtered out
    @(posedge clk);
    #1 btn = B_RIGHT;
    repeat (5) @(posedge clk);
    #1 btn = B_NONE;
    repeat (20) @(posedge clk);
    tick(B_NONE, 1, 315, 0, 0, S_IDLE);
`endif

    repeat (4) @(posedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // watchdog
  initial begin
    #3000000;
    errors++;
    $display("FAIL watchdog: run did not complete, %0d expectations pending", exp_q.size());
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
